hr_timer_driver: RTL and testbench

//  Hardware Avalon-MM initiator for the 16-bit-register interval timer (6 regs: status, control,

---
 rtl/hr_timer_driver.sv | 218 +++++++++++++++++++++
 tb/tb_hr_timer_driver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hr_timer_driver.sv
// Avalon-MM initiator that drives a 16-bit-register interval timer from simple fabric commands.
// It issues the start/stop/snapshot register sequences, services the timer irq and counts timeouts.
module hr_timer_driver #(
  parameter int unsigned TICK_W         = 16,
  parameter bit          CLEAR_ON_START = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  // Command handshake: a command transfers on a rising clk edge where cmd_valid & cmd_ready;
  // cmd_op/cmd_period/cmd_continuous are sampled only on that edge, and cmd_ready never
  // depends on cmd_valid.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_continuous,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              timer_irq,
  output logic              busy,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [3:0]        dbg_state
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_SNAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PER_L  = 3'd2;
  localparam logic [2:0] A_PER_H  = 3'd3;
  localparam logic [2:0] A_SNAP_L = 3'd4;
  localparam logic [2:0] A_SNAP_H = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_PL    = 4'd1,
    S_WR_PH    = 4'd2,
    S_WR_CTL   = 4'd3,
    S_WR_STOP  = 4'd4,
    S_WR_SNAP  = 4'd5,
    S_RD_SNL   = 4'd6,
    S_RD_SNH   = 4'd7,
    S_RD_LAST  = 4'd8,
    S_CLR_ST   = 4'd9,
    S_CLR_WAIT = 4'd10
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_rdy_en;
  logic [15:0]         r_period_h;
  logic                r_cont;
  logic                r_av_cs;
  logic                r_av_wn;
  logic [2:0]          r_av_addr;
  logic [15:0]         r_av_wd;
  logic                w_cs;
  logic                w_wn;
  logic [2:0]          w_addr;
  logic [15:0]         w_wd;
  logic [31:0]         r_snap;
  logic                r_snap_valid;
  logic                r_tick;
  logic [TICK_W-1:0]   r_tick_count;
  logic                w_accept;
  logic                w_clear_cnt;
  logic                w_inc_cnt;

  // The irq term keeps a pending timeout ahead of any waiting command.
  assign cmd_ready   = r_rdy_en & (r_state == S_IDLE) & ~timer_irq;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_clear_cnt = w_accept & ((cmd_op == OP_CLEAR) | ((cmd_op == OP_START) & CLEAR_ON_START));
  assign w_inc_cnt   = (r_state == S_IDLE) & (w_next_state == S_CLR_ST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (timer_irq) begin
          w_next_state = S_CLR_ST;
        end else if (w_accept) begin
          case (cmd_op)
            OP_START: w_next_state = S_WR_PL;
            OP_STOP:  w_next_state = S_WR_STOP;
            OP_SNAP:  w_next_state = S_WR_SNAP;
            default:  w_next_state = S_IDLE;
          endcase
        end
      end
      S_WR_PL:    w_next_state = S_WR_PH;
      S_WR_PH:    w_next_state = S_WR_CTL;
      S_WR_CTL:   w_next_state = S_IDLE;
      S_WR_STOP:  w_next_state = S_IDLE;
      S_WR_SNAP:  w_next_state = S_RD_SNL;
      S_RD_SNL:   w_next_state = S_RD_SNH;
      S_RD_SNH:   w_next_state = S_RD_LAST;
      S_RD_LAST:  w_next_state = S_IDLE;
      S_CLR_ST:   w_next_state = S_CLR_WAIT;
      S_CLR_WAIT: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Bus fields are decoded from the next state so the registered strobe lines up with that state.
  always_comb begin
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = 3'd0;
    w_wd   = 16'h0000;
    case (w_next_state)
      S_WR_PL: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_PER_L;
        w_wd   = cmd_period[15:0];
      end
      S_WR_PH: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_PER_H;
        w_wd   = r_period_h;
      end
      S_WR_CTL: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_CTRL;
        w_wd   = {12'h000, 1'b0, 1'b1, r_cont, 1'b1};
      end
      S_WR_STOP: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_CTRL;
        w_wd   = 16'h0008;
      end
      S_WR_SNAP: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_SNAP_L;
      end
      S_RD_SNL: begin
        w_cs   = 1'b1;
        w_addr = A_SNAP_L;
      end
      S_RD_SNH: begin
        w_cs   = 1'b1;
        w_addr = A_SNAP_H;
      end
      S_CLR_ST: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = A_STATUS;
      end
      default: begin
        w_cs   = 1'b0;
        w_wn   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rdy_en     <= 1'b0;
      r_period_h   <= 16'h0000;
      r_cont       <= 1'b0;
      r_av_cs      <= 1'b0;
      r_av_wn      <= 1'b1;
      r_av_addr    <= 3'd0;
      r_av_wd      <= 16'h0000;
      r_snap       <= 32'h0000_0000;
      r_snap_valid <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_rdy_en     <= 1'b1;
      r_av_cs      <= w_cs;
      r_av_wn      <= w_wn;
      r_av_addr    <= w_addr;
      r_av_wd      <= w_wd;
      r_snap_valid <= (r_state == S_RD_LAST);
      r_tick       <= w_inc_cnt;
      if (w_accept) begin
        r_period_h <= cmd_period[31:16];
        r_cont     <= cmd_continuous;
      end
      // Read data arrives one cycle after its address, hence the one-state lag.
      if (r_state == S_RD_SNH) r_snap[15:0]  <= av_readdata;
      if (r_state == S_RD_LAST) r_snap[31:16] <= av_readdata;
      if (w_clear_cnt) begin
        r_tick_count <= '0;
      end else if (w_inc_cnt) begin
        r_tick_count <= r_tick_count + TICK_W'(1);
      end
    end
  end

  assign av_chipselect = r_av_cs;
  assign av_write_n    = r_av_wn;
  assign av_address    = r_av_addr;
  assign av_writedata  = r_av_wd;
  assign busy          = (r_state != S_IDLE);
  assign snap_valid    = r_snap_valid;
  assign snap_value    = r_snap;
  assign tick          = r_tick;
  assign tick_count    = r_tick_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_hr_timer_driver.sv
// Directed bench for hr_timer_driver against a small behavioural model of the interval timer slave.
module tb_hr_timer_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        timer_irq;
  logic        busy;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic        tick;
  logic [3:0]  tick_count;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hr_timer_driver #(.TICK_W(4), .CLEAR_ON_START(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .timer_irq(timer_irq),
    .busy(busy), .snap_valid(snap_valid), .snap_value(snap_value),
    .tick(tick), .tick_count(tick_count), .dbg_state(dbg_state)
  );

  // Timer slave model: registered readdata, irq registered from timeout (drops one cycle late).
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_period = 32'd0;
  logic [31:0] m_snap = 32'd0;
  logic [3:0]  m_ctl = 4'd0;
  logic        m_run = 1'b0;
  logic        m_timeout = 1'b0;
  logic        m_irq = 1'b0;
  logic [15:0] m_rd = 16'hDEAD;
  logic        m_set_cnt = 1'b0;
  logic [31:0] m_set_val = 32'd0;
  logic        m_set_to = 1'b0;

  assign timer_irq   = m_irq;
  assign av_readdata = m_rd;

  always @(posedge clk) begin
    m_irq <= m_timeout & m_ctl[0];
    m_rd  <= 16'hDEAD;
    if (m_run) begin
      if (m_cnt == 32'd0) begin
        m_timeout <= 1'b1;
        m_cnt     <= m_period;
        if (!m_ctl[1]) m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 32'd1;
      end
    end
    if (av_chipselect && av_write_n) begin
      case (av_address)
        3'd0:    m_rd <= {15'd0, m_timeout};
        3'd1:    m_rd <= {12'd0, m_ctl};
        3'd4:    m_rd <= m_snap[15:0];
        3'd5:    m_rd <= m_snap[31:16];
        default: m_rd <= 16'h0000;
      endcase
    end
    if (av_chipselect && !av_write_n) begin
      case (av_address)
        3'd0: m_timeout <= 1'b0;
        3'd1: begin
          m_ctl <= av_writedata[3:0];
          if (av_writedata[2]) m_run <= 1'b1;
          if (av_writedata[3]) m_run <= 1'b0;
        end
        3'd2: begin
          m_period[15:0] <= av_writedata;
          m_cnt          <= {m_period[31:16], av_writedata};
        end
        3'd3: begin
          m_period[31:16] <= av_writedata;
          m_cnt           <= {av_writedata, m_period[15:0]};
        end
        3'd4: m_snap <= m_cnt;
        default: ;
      endcase
    end
    if (m_set_cnt) m_cnt <= m_set_val;
    if (m_set_to) begin
      m_timeout <= 1'b1;
      m_ctl[0]  <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bw(input logic cs, input logic wn, input logic [2:0] a,
                                     input logic [15:0] d);
    return {11'd0, cs, wn, a, d};
  endfunction

  function automatic logic [31:0] bus_now();
    return bw(av_chipselect, av_write_n, av_address, av_writedata);
  endfunction

  // Call at a negedge; returns at the negedge just after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic cont);
    int n;
    cmd_op = op;
    cmd_period = per;
    cmd_continuous = cont;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check_eq("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_period = 32'hFFFF_FFFF;
    cmd_continuous = 1'b0;
    cmd_op = 2'b00;
  endtask

  task automatic wait_ticks(input string tag, input int want, input int budget);
    int seen;
    int n;
    seen = 0;
    n = 0;
    while (seen < want && n < budget) begin
      @(negedge clk);
      n++;
      if (tick) seen++;
    end
    check_eq(tag, seen, want);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_period = 32'd0;
    cmd_continuous = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check_eq("rst_bus", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0000));
    check_eq("rst_outs", {busy, snap_valid, tick, tick_count}, 32'd0);
    check_eq("rst_snap", snap_value, 32'd0);
    reset_n = 1'b1;
    #1 check_eq("rdy_first_cycle", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("rdy_after", {31'd0, cmd_ready}, 32'd1);

    // START period 9, continuous.
    send_cmd(2'b00, 32'h0000_0009, 1'b1);
    check_eq("start_pl", bus_now(), bw(1'b1, 1'b0, 3'd2, 16'h0009));
    check_eq("start_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("start_ph", bus_now(), bw(1'b1, 1'b0, 3'd3, 16'h0000));
    @(negedge clk);
    check_eq("start_ctl", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0007));
    @(negedge clk);
    check_eq("start_done", {busy, av_chipselect}, 32'd0);
    wait_ticks("start_ticks", 5, 200);
    check_eq("cnt_5", tick_count, 32'd5);

    // STOP: one write, no further irq.
    send_cmd(2'b01, 32'h0, 1'b0);
    check_eq("stop_wr", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0008));
    @(negedge clk);
    check_eq("stop_idle", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0000));
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (timer_irq) cnt++;
    end
    check_eq("stop_no_irq", cnt, 32'd0);
    check_eq("stop_cnt", tick_count, 32'd5);

    // One-shot START with a non-zero high half; count cleared on start.
    send_cmd(2'b00, 32'h0003_0004, 1'b0);
    check_eq("os_pl", bus_now(), bw(1'b1, 1'b0, 3'd2, 16'h0004));
    check_eq("os_cnt_clr", tick_count, 32'd0);
    @(negedge clk);
    check_eq("os_ph", bus_now(), bw(1'b1, 1'b0, 3'd3, 16'h0003));
    @(negedge clk);
    check_eq("os_ctl", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0005));
    @(negedge clk);
    send_cmd(2'b01, 32'h0, 1'b0);
    check_eq("os_stop", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0008));
    @(negedge clk);

    // SNAPSHOT of counter 0x0001_2345.
    m_set_val = 32'h0001_2345;
    m_set_cnt = 1'b1;
    @(negedge clk);
    m_set_cnt = 1'b0;
    send_cmd(2'b10, 32'h0, 1'b0);
    check_eq("snap_wr", bus_now(), bw(1'b1, 1'b0, 3'd4, 16'h0000));
    @(negedge clk);
    check_eq("snap_rdl", bus_now(), bw(1'b1, 1'b1, 3'd4, 16'h0000));
    @(negedge clk);
    check_eq("snap_rdh", bus_now(), bw(1'b1, 1'b1, 3'd5, 16'h0000));
    @(negedge clk);
    check_eq("snap_last", {busy, snap_valid, av_chipselect}, 32'h4);
    @(negedge clk);
    check_eq("snap_valid", {31'd0, snap_valid}, 32'd1);
    check_eq("snap_value", snap_value, 32'h0001_2345);
    @(negedge clk);
    check_eq("snap_pulse_end", {31'd0, snap_valid}, 32'd0);

    // irq already pending while a CLEAR is held: service first, then accept.
    m_set_to = 1'b1;
    @(negedge clk);
    m_set_to = 1'b0;
    @(negedge clk);
    check_eq("irq_up", {31'd0, timer_irq}, 32'd1);
    check_eq("irq_rdy_low", {31'd0, cmd_ready}, 32'd0);
    cmd_op = 2'b11;
    cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("clr_st_bus", bus_now(), bw(1'b1, 1'b0, 3'd0, 16'h0000));
    check_eq("clr_st_tick", {tick, cmd_ready, tick_count}, 32'h21);
    @(negedge clk);
    check_eq("clr_wait", {cmd_ready, av_chipselect, tick}, 32'd0);
    @(negedge clk);
    check_eq("clr_rdy", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("clear_cnt", tick_count, 32'd0);
    check_eq("clear_nobus", {busy, av_chipselect}, 32'd0);

    // 17 timeouts with a 4-bit counter wrap to 1.
    send_cmd(2'b00, 32'h0000_000B, 1'b1);
    check_eq("w_pl", bus_now(), bw(1'b1, 1'b0, 3'd2, 16'h000B));
    wait_ticks("wrap_ticks", 17, 400);
    send_cmd(2'b01, 32'h0, 1'b0);
    check_eq("wrap_stop", bus_now(), bw(1'b1, 1'b0, 3'd1, 16'h0008));
    repeat (20) @(negedge clk);
    check_eq("wrap_cnt", tick_count, 32'd1);

    // Async reset during RD_SNH.
    send_cmd(2'b10, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rs_rdh", bus_now(), bw(1'b1, 1'b1, 3'd5, 16'h0000));
    reset_n = 1'b0;
    #1 check_eq("rs_bus_idle", bus_now(), bw(1'b0, 1'b1, 3'd0, 16'h0000));
    check_eq("rs_outs", {busy, cmd_ready, tick_count}, 32'd0);
    check_eq("rs_snap", snap_value, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_eq("rs_rdy_first", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("rs_rdy_after", {31'd0, cmd_ready}, 32'd1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (snap_valid) cnt++;
    end
    check_eq("rs_no_snap", cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
